apb4_master: RTL and testbench

- APB4 requester: accepts single register-access commands on a valid/ready command port and drives one APB4 transfer (SETUP then ACCESS) per command.
- Returns read data and error on a valid/ready response port.
- Sits on the initiator side of the APB4 bus that the team's register-block slaves respond to. Used by test harnesses, debug bridges and CPU-side adapters.
- Adds a programmable ACCESS-phase timeout so that a hung slave cannot lock the bus.

---
 rtl/apb4_pkg.sv | 31 +++
 rtl/apb4_timeout_ctr.sv | 29 ++
 rtl/apb4_master.sv | 114 +++++++++++
 tb/tb_apb4_master.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb4_pkg.sv
// Shared types and constants for the APB4 requester and the benches that drive
// or answer it.
package apb4_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb4_state_t;

  localparam logic [2:0] APB_PPROT_DEFAULT = 3'b000;

  // Default bus geometry of the register-block slaves.
  localparam int APB4_ADDR_W = 4;
  localparam int APB4_DATA_W = 32;

  typedef struct packed {
    logic                     write;
    logic [APB4_ADDR_W-1:0]   addr;
    logic [APB4_DATA_W-1:0]   wdata;
    logic [APB4_DATA_W/8-1:0] strb;
  } apb4_cmd_t;

  // Width of a counter that reaches 'cycles'; at least 1 bit so a disabled
  // timeout still elaborates.
  function automatic int unsigned tmo_width(input int unsigned cycles);
    return (cycles == 0) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/apb4_timeout_ctr.sv
// ACCESS-phase wait counter: counts stalled cycles and flags the last allowed
// one. TIMEOUT_CYCLES = 0 freezes the counter and never expires.
module apb4_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  import apb4_pkg::*;

  localparam int unsigned CW   = tmo_width(TIMEOUT_CYCLES);
  localparam int unsigned LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam bit          ON   = (TIMEOUT_CYCLES != 0);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)            cnt <= '0;
    else if (clr)       cnt <= '0;
    else if (en && ON)  cnt <= cnt + 1'b1;
  end

  // Expired means "this stalled cycle is the last one allowed".
  assign expired = ON && (cnt == CW'(LAST));

endmodule

// File: rtl/apb4_master.sv
// APB4 requester: one SETUP+ACCESS transfer per valid/ready command, response
// returned on a valid/ready port, with an optional ACCESS-phase timeout.
module apb4_master #(
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [2:0]              pprot,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pready,
  input  logic                    pslverr
);
  import apb4_pkg::*;

  apb4_state_t state;
  logic        tmo_clr, tmo_en, tmo_expired;

  assign cmd_ready = (state == IDLE);
  assign pprot     = APB_PPROT_DEFAULT;

  // Counter clears on the accept edge, i.e. on entry to SETUP.
  assign tmo_clr = (state == IDLE) && cmd_valid;
  assign tmo_en  = (state == ACCESS) && !pready;

  apb4_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      pstrb       <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            state  <= SETUP;
            psel   <= 1'b1;
            pwrite <= cmd_write;
            paddr  <= cmd_addr;
            // Reads put nothing on the write lanes.
            pwdata <= cmd_write ? cmd_wdata : '0;
            pstrb  <= cmd_write ? cmd_strb  : '0;
          end
        end
        SETUP: begin
          state   <= ACCESS;
          penable <= 1'b1;
        end
        ACCESS: begin
          if (pready) begin
            state       <= RESP;
            psel        <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= pwrite ? '0 : prdata;
            rsp_err     <= pslverr;
            rsp_timeout <= 1'b0;
          end else if (tmo_expired) begin
            state       <= RESP;
            psel        <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb4_master.sv
// Randomized scoreboard bench for apb4_master: a slave model answers the bus,
// a monitor compares every presented response against a reference queue.
module tb_apb4_master;
  import apb4_pkg::*;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [3:0]  cmd_addr, cmd_strb;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        psel, penable, pwrite;
  logic [3:0]  paddr, pstrb;
  logic [31:0] pwdata, prdata;
  logic [2:0]  pprot;
  logic        pready, pslverr;

  apb4_master #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  typedef struct {
    apb4_cmd_t   cmd;
    int          waits;   // pready=0 cycles the slave inserts before answering
    bit          err;
    logic [31:0] rdata;
  } xfer_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } rsp_t;

  xfer_t slv_q[$];
  rsp_t  exp_q[$];
  int    errs = 0, checks = 0;
  int    cyc = 0;
  int    rdy_mode = 1;       // 0 random, 1 always ready, 2 hold off 5 cycles
  int    hs_edge = -1, acc_edge = 0;
  int    wt_tab[8];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: outcome follows only from the slave's wait count.
  function automatic rsp_t model(input xfer_t x);
    rsp_t r;
    if (x.waits >= TO) begin
      r.rdata = 32'h0; r.err = 1'b1; r.tmo = 1'b1;
    end else begin
      r.rdata = x.cmd.write ? 32'h0 : x.rdata; r.err = x.err; r.tmo = 1'b0;
    end
    return r;
  endfunction

  function automatic apb4_cmd_t bus_img(input apb4_cmd_t c);
    apb4_cmd_t e;
    e = c;
    if (!c.write) begin e.wdata = '0; e.strb = '0; end
    return e;
  endfunction

  function automatic apb4_cmd_t mk(input bit w, input logic [3:0] a,
                                   input logic [31:0] d, input logic [3:0] s);
    apb4_cmd_t c;
    c.write = w; c.addr = a; c.wdata = d; c.strb = s;
    return c;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input apb4_cmd_t c, input int waits, input bit err, input logic [31:0] rd);
    xfer_t x;
    int n;
    cmd_valid = 1'b1; cmd_write = c.write; cmd_addr = c.addr;
    cmd_wdata = c.wdata; cmd_strb = c.strb;
    n = 0;
    while (!cmd_ready && n < 300) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      chk("accept_timeout", 64'(cmd_ready), 64'(1));
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    x.cmd = c; x.waits = waits; x.err = err; x.rdata = rd;
    slv_q.push_back(x);
    exp_q.push_back(model(x));
    acc_edge = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom); cmd_addr = 4'($urandom);
    cmd_wdata = $urandom;     cmd_strb = 4'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || slv_q.size() != 0 || !cmd_ready) && n < 400) begin
      @(negedge clk); n++;
    end
    if (n >= 400) chk("idle_timeout", 64'(exp_q.size()), 64'(0));
  endtask

  // Response monitor / consumer
  int   held;
  bit   take;
  logic [33:0] mon_e;
  initial forever begin
    @(negedge clk);
    if (rst) begin
      rsp_ready = 1'b0; held = 0;
    end else begin
      chk("cmd_ready", 64'(cmd_ready), 64'(exp_q.size() == 0));
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 64'(rsp_valid), 64'(0));
          rsp_ready = 1'b1;
        end else begin
          mon_e = exp_q[0];
          chk("rsp", 64'({rsp_rdata, rsp_err, rsp_timeout}), 64'(mon_e));
          case (rdy_mode)
            1:       take = 1'b1;
            2:       take = (held >= 5);
            default: take = ($urandom_range(0, 2) != 0);
          endcase
          held++;
          rsp_ready = take;
          if (take) begin
            void'(exp_q.pop_front());
            hs_edge = cyc;
            held = 0;
          end
        end
      end else begin
        rsp_ready = 1'($urandom_range(0, 1));
        held = 0;
      end
    end
  end

  // Slave model and bus protocol checks
  xfer_t     cur;
  apb4_cmd_t img;
  int        acc_cnt;
  bit        in_acc, was_setup;
  initial forever begin
    @(negedge clk);
    if (rst) begin
      pready = 1'b0; pslverr = 1'b0; prdata = '0;
      in_acc = 1'b0; acc_cnt = 0; was_setup = 1'b0;
    end else begin
      if (psel && !penable) begin
        if (slv_q.size() == 0) chk("setup_unexpected", 64'(psel), 64'(0));
        else begin
          cur = slv_q.pop_front();
          img = bus_img(cur.cmd);
          chk("setup", 64'({pwrite, paddr, pwdata, pstrb}), 64'(img));
          chk("pprot", 64'(pprot), 64'(0));
        end
        acc_cnt = 0;
        pready = 1'($urandom_range(0, 1)); pslverr = 1'($urandom); prdata = $urandom;
      end else if (psel && penable) begin
        if (acc_cnt == 0) chk("setup_len", 64'(was_setup), 64'(1));
        chk("access_hold", 64'({pwrite, paddr, pwdata, pstrb}), 64'(img));
        if (acc_cnt == cur.waits) begin
          pready = 1'b1; pslverr = cur.err;
          prdata = cur.cmd.write ? $urandom : cur.rdata;
        end else begin
          pready = 1'b0; pslverr = 1'($urandom); prdata = $urandom;
        end
        acc_cnt++;
        in_acc = 1'b1;
      end else begin
        chk("penable_idle", 64'(penable), 64'(0));
        if (in_acc) chk("access_len", 64'(acc_cnt), 64'((cur.waits >= TO) ? TO : cur.waits + 1));
        in_acc = 1'b0;
        pready = 1'($urandom_range(0, 1)); pslverr = 1'($urandom); prdata = $urandom;
      end
      was_setup = psel && !penable;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
    wt_tab = '{0, 0, 1, 2, 3, 15, 16, 40};
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_apb", 64'({psel, penable, pwrite, paddr, pwdata, pstrb, pprot}), 64'(0));
    chk("reset_rsp", 64'({rsp_valid, rsp_rdata, rsp_err, rsp_timeout}), 64'(0));
    chk("reset_cmd_ready", 64'(cmd_ready), 64'(1));
    #1 rst = 1'b0;
    @(negedge clk);

    // Zero-wait write: latency of psel, penable, rsp_valid
    rdy_mode = 1;
    send(mk(1'b1, 4'h4, 32'hA5A5_5A5A, 4'hF), 0, 1'b0, 32'h0);
    chk("lat_psel", 64'({psel, penable}), 64'(2'b10));
    @(negedge clk);
    chk("lat_penable", 64'({psel, penable}), 64'(2'b11));
    @(negedge clk);
    chk("lat_rsp_valid", 64'({rsp_valid, psel, penable}), 64'(3'b100));
    wait_idle();

    // Read with 3 wait states, write with pslverr, stuck slave timeout
    send(mk(1'b0, 4'h8, 32'hFFFF_FFFF, 4'hF), 3, 1'b0, 32'h1234_5678);
    wait_idle();
    send(mk(1'b1, 4'hC, 32'h0BAD_F00D, 4'h5), 0, 1'b1, 32'hDEAD_BEEF);
    wait_idle();
    send(mk(1'b0, 4'h0, 32'h0, 4'h0), 1000, 1'b0, 32'hCAFE_0001);
    wait_idle();
    send(mk(1'b0, 4'h2, 32'h0, 4'h0), TO - 1, 1'b0, 32'h5555_AAAA);
    wait_idle();

    // Back-to-back with response held off
    rdy_mode = 2;
    send(mk(1'b1, 4'h1, 32'h1111_2222, 4'h3), 0, 1'b0, 32'h0);
    send(mk(1'b0, 4'h3, 32'h0, 4'h0), 0, 1'b0, 32'h7777_8888);
    chk("b2b_spacing", 64'(acc_edge), 64'(hs_edge + 1));
    wait_idle();
    rdy_mode = 1;

    // Reset in the middle of ACCESS
    send(mk(1'b0, 4'h6, 32'h0, 4'h0), 1000, 1'b0, 32'h0);
    n = 0;
    while (!(psel && penable) && n < 20) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    slv_q.delete();
    @(negedge clk);
    chk("rst_mid_bus", 64'({psel, penable, rsp_valid}), 64'(0));
    chk("rst_mid_ready", 64'(cmd_ready), 64'(1));
    #1 rst = 1'b0;
    @(negedge clk);
    send(mk(1'b1, 4'h9, 32'h0F0F_F0F0, 4'hC), 1, 1'b0, 32'h0);
    wait_idle();

    // Randomized traffic
    rdy_mode = 0;
    for (int i = 0; i < 60; i++) begin
      send(mk(1'($urandom), 4'($urandom), $urandom, 4'($urandom)),
           wt_tab[$urandom_range(0, 7)], 1'($urandom), $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle();
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
